// File: rtl/bon_flag_collector.sv
// Snoops BON's request bus and flag output, queues each flagged address in a FWFT FIFO,
// and drains the queue to the host once BON signals fin.
module bon_flag_collector #(
  parameter int ADDR_W = 10,
  parameter int RES_W  = 10,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              en,
  input  logic [ADDR_W-1:0] addr,
  input  logic              flag,
  input  logic              fin,
  input  logic [RES_W-1:0]  result,
  output logic              rd_valid,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_ready,
  output logic              rd_last,
  output logic [CNT_W-1:0]  hit_count,
  output logic              overflow,
  output logic              done,
  output logic [RES_W-1:0]  done_result
);

  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DRAIN,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [ADDR_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [PW:0]       occ;
  logic [ADDR_W-1:0] last_addr;
  logic              last_valid;

  logic collect_cyc;
  logic hit, dup, uniq;
  logic full, pop, push, drop;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else if (clear) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (en) state_nx = fin ? DRAIN : COLLECT;
      COLLECT: if (fin) state_nx = DRAIN;
      DRAIN:   if (occ == '0) state_nx = DONE;
      DONE:    state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs and per-cycle capture decisions; the IDLE->COLLECT cycle already captures.
  always_comb begin
    collect_cyc = (state == COLLECT) || ((state == IDLE) && en);
    rd_valid    = (occ != '0);
    rd_addr     = rd_valid ? mem[rd_ptr] : '0;
    rd_last     = rd_valid && (state == DRAIN) && (occ == (PW+1)'(1));
    done        = (state == DONE);
    full        = (occ == (PW+1)'(DEPTH));
    hit         = collect_cyc && en && flag;
    dup         = last_valid && (addr == last_addr);
    uniq        = hit && !dup;
    pop         = rd_valid && rd_ready;
    push        = uniq && (!full || pop);
    drop        = uniq && full && !pop;
  end

  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr] <= addr;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      occ         <= '0;
      last_addr   <= '0;
      last_valid  <= 1'b0;
      hit_count   <= '0;
      overflow    <= 1'b0;
      done_result <= '0;
    end else if (clear) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      occ         <= '0;
      last_addr   <= '0;
      last_valid  <= 1'b0;
      hit_count   <= '0;
      overflow    <= 1'b0;
      done_result <= '0;
    end else begin
      if (push) begin
        wr_ptr     <= wr_ptr + 1'b1;
        last_addr  <= addr;
        last_valid <= 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
      if (uniq && (hit_count != '1)) hit_count <= hit_count + 1'b1;
      if (drop) overflow <= 1'b1;
      if (collect_cyc && fin) done_result <= result;
    end
  end

endmodule

// File: tb/tb_bon_flag_collector.sv
// Directed bench for bon_flag_collector: capture, duplicate suppression, overflow,
// full-FIFO pop/push, fin corner cases, async reset and soft clear.
module tb_bon_flag_collector;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic        en;
  logic [9:0]  addr;
  logic        flag;
  logic        fin;
  logic [9:0]  result;
  logic        rd_valid;
  logic [9:0]  rd_addr;
  logic        rd_ready;
  logic        rd_last;
  logic [10:0] hit_count;
  logic        overflow;
  logic        done;
  logic [9:0]  done_result;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bon_flag_collector #(
    .ADDR_W(10),
    .RES_W (10),
    .DEPTH (16),
    .CNT_W (11)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .en         (en),
    .addr       (addr),
    .flag       (flag),
    .fin        (fin),
    .result     (result),
    .rd_valid   (rd_valid),
    .rd_addr    (rd_addr),
    .rd_ready   (rd_ready),
    .rd_last    (rd_last),
    .hit_count  (hit_count),
    .overflow   (overflow),
    .done       (done),
    .done_result(done_result)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    en = 1'b0; flag = 1'b0; addr = '0; fin = 1'b0; result = '0; rd_ready = 1'b0;
  endtask

  task automatic do_clear();
    idle_inputs();
    clear = 1'b1;
    cyc();
    clear = 1'b0;
  endtask

  task automatic hit_one(input logic [9:0] a);
    en = 1'b1; flag = 1'b1; addr = a;
    cyc();
    en = 1'b0; flag = 1'b0;
  endtask

  task automatic pop_expect(input string tag, input logic [9:0] a, input logic last);
    check_eq({tag, "_valid"}, rd_valid, 1);
    check_eq({tag, "_addr"}, rd_addr, a);
    check_eq({tag, "_last"}, rd_last, last);
    rd_ready = 1'b1;
    cyc();
    rd_ready = 1'b0;
  endtask

  task automatic basic_run(input string tag);
    hit_one(10'd5);
    hit_one(10'd200);
    hit_one(10'd1023);
    fin = 1'b1; result = 10'h155;
    cyc();
    check_eq({tag, "_hits"}, hit_count, 3);
    pop_expect({tag, "_r0"}, 10'd5, 1'b0);
    pop_expect({tag, "_r1"}, 10'd200, 1'b0);
    pop_expect({tag, "_r2"}, 10'd1023, 1'b1);
    check_eq({tag, "_empty"}, rd_valid, 0);
    cyc();
    check_eq({tag, "_done"}, done, 1);
    check_eq({tag, "_result"}, done_result, 10'h155);
    check_eq({tag, "_ovf"}, overflow, 0);
    check_eq({tag, "_hits_end"}, hit_count, 3);
  endtask

  initial begin
    int nread;
    idle_inputs();
    clear = 1'b0;
    rst = 1'b0;
    cyc();
    cyc();
    check_eq("rst_valid", rd_valid, 0);
    check_eq("rst_addr", rd_addr, 0);
    check_eq("rst_hits", hit_count, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_last", rd_last, 0);
    check_eq("rst_ovf", overflow, 0);
    check_eq("rst_result", done_result, 0);
    rst = 1'b1;
    cyc();

    basic_run("basic");

    // Soft clear from DONE
    do_clear();
    check_eq("clr_done", done, 0);
    check_eq("clr_result", done_result, 0);
    check_eq("clr_hits", hit_count, 0);
    check_eq("clr_valid", rd_valid, 0);

    // Held address counts once
    en = 1'b1; flag = 1'b1; addr = 10'd7;
    repeat (4) cyc();
    addr = 10'd8;
    cyc();
    en = 1'b0; flag = 1'b0;
    check_eq("dup_hits", hit_count, 2);
    pop_expect("dup_r0", 10'd7, 1'b0);
    pop_expect("dup_r1", 10'd8, 1'b0);
    check_eq("dup_empty", rd_valid, 0);

    // Overflow with no reader
    do_clear();
    for (int i = 0; i < 20; i++) hit_one(10'(i));
    check_eq("ovf_hits", hit_count, 20);
    check_eq("ovf_flag", overflow, 1);
    for (int i = 0; i < 16; i++) pop_expect("ovf_rd", 10'(i), 1'b0);
    check_eq("ovf_empty", rd_valid, 0);

    // Same 20 hits with the reader always ready
    do_clear();
    rd_ready = 1'b1;
    nread = 0;
    en = 1'b1; flag = 1'b1;
    for (int i = 0; i < 24; i++) begin
      if (i < 20) addr = 10'(i);
      else begin en = 1'b0; flag = 1'b0; end
      cyc();
      if (rd_valid) begin
        check_eq("stream_addr", rd_addr, nread);
        nread++;
      end
    end
    rd_ready = 1'b0;
    check_eq("stream_count", nread, 20);
    check_eq("stream_ovf", overflow, 0);
    check_eq("stream_hits", hit_count, 20);

    // Full FIFO, push and pop in the same cycle
    do_clear();
    for (int i = 0; i < 16; i++) hit_one(10'(i));
    en = 1'b1; flag = 1'b1; addr = 10'd99; rd_ready = 1'b1;
    cyc();
    en = 1'b0; flag = 1'b0; rd_ready = 1'b0;
    check_eq("fullpp_ovf", overflow, 0);
    check_eq("fullpp_hits", hit_count, 17);
    for (int i = 1; i < 16; i++) pop_expect("fullpp_rd", 10'(i), 1'b0);
    pop_expect("fullpp_tail", 10'd99, 1'b0);
    check_eq("fullpp_empty", rd_valid, 0);

    // fin without any hits
    do_clear();
    en = 1'b1; fin = 1'b1; result = 10'h0AA;
    cyc();
    en = 1'b0;
    check_eq("nohit_valid", rd_valid, 0);
    cyc();
    check_eq("nohit_done", done, 1);
    check_eq("nohit_hits", hit_count, 0);
    check_eq("nohit_result", done_result, 10'h0AA);

    // Hit coinciding with fin is kept
    do_clear();
    hit_one(10'd1);
    en = 1'b1; flag = 1'b1; addr = 10'd42; fin = 1'b1; result = 10'h2AA;
    cyc();
    en = 1'b0; flag = 1'b0;
    check_eq("finhit_hits", hit_count, 2);
    pop_expect("finhit_r0", 10'd1, 1'b0);
    pop_expect("finhit_r1", 10'd42, 1'b1);
    cyc();
    check_eq("finhit_done", done, 1);
    check_eq("finhit_result", done_result, 10'h2AA);

    // Async reset in the middle of a run
    do_clear();
    for (int i = 0; i < 5; i++) hit_one(10'(100 + i));
    check_eq("pre_rst_hits", hit_count, 5);
    #2 rst = 1'b0;
    #1;
    check_eq("arst_valid", rd_valid, 0);
    check_eq("arst_addr", rd_addr, 0);
    check_eq("arst_hits", hit_count, 0);
    cyc();
    rst = 1'b1;
    cyc();
    basic_run("after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
